// File: rtl/uio_arb_pkg.sv
// rtl/uio_arb_pkg.sv - shared types and counter widths for the uio pad arbiter
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    OWN
  } state_t;

  localparam int MAX_REQ = 4;
  localparam int TURN_W  = 3;
  localparam int HOLD_W  = 8;
  localparam logic [HOLD_W-1:0] HOLD_SAT = 8'd255;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Returns the first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan farthest-to-nearest so the candidate closest to ptr wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < N; i++) begin
        if (i == (int'(ptr) + k) % N && req[i]) begin
          valid = 1'b1;
          idx   = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uio_port_arbiter.sv
// rtl/uio_port_arbiter.sv - round-robin owner of the shared uio pads
// Inserts an all-inputs turnaround window before every grant and caps ownership time.
module uio_port_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_out,
  input  logic [8*NUM_REQ-1:0] req_oe,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           rd_data,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       ptr;
  logic [TURN_W-1:0]   turn_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       ptr_next;
  logic [NUM_REQ-1:0]  own_mask;
  logic [NUM_REQ-1:0]  pick_mask;
  logic [7:0]          own_out;
  logic [7:0]          own_oe;
  logic                own_exit;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    own_mask  = '0;
    pick_mask = '0;
    own_out   = '0;
    own_oe    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_mask[i]  = (IW'(i) == owner);
      pick_mask[i] = (IW'(i) == pick_idx);
      if (IW'(i) == owner) begin
        own_out = req_out[8*i +: 8];
        own_oe  = req_oe[8*i +: 8];
      end
    end
  end

  assign ptr_next = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // Voluntary release, or forced release once the hold budget is spent and someone else waits.
  assign own_exit = !(|(req & own_mask)) ||
                    ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (|(req & ~own_mask)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      turn_cnt <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      rd_data  <= '0;
      uio_out  <= '0;
      uio_oe   <= '0;
    end else begin
      rd_data <= uio_in;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick_idx;
            turn_cnt <= TURN_LOAD;
            state    <= TURN;
          end
        end
        TURN: begin
          if (turn_cnt == '0) begin
            // Winner is re-evaluated here in case the latched one dropped its request.
            if (pick_valid) begin
              owner    <= pick_idx;
              grant    <= pick_mask;
              ptr      <= ptr_next;
              hold_cnt <= '0;
              state    <= OWN;
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        OWN: begin
          if (own_exit) begin
            grant   <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
            if (|req) begin
              owner    <= pick_idx;
              turn_cnt <= TURN_LOAD;
              state    <= TURN;
            end else begin
              state <= IDLE;
            end
          end else begin
            uio_out <= own_out;
            uio_oe  <= own_oe;
            if (hold_cnt != HOLD_SAT) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uio_port_arbiter.sv
// tb/tb_uio_port_arbiter.sv - directed self-checking bench for uio_port_arbiter
module tb_uio_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;

  logic [1:0]  a_req;
  logic [15:0] a_out, a_oe;
  logic [1:0]  a_grant;
  logic [7:0]  a_rd, a_uin, a_uout, a_uoe;

  logic [1:0]  b_req;
  logic [15:0] b_out, b_oe;
  logic [1:0]  b_grant;
  logic [7:0]  b_rd, b_uin, b_uout, b_uoe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] req;
    logic [7:0] o0, e0, o1, e1;
    logic [1:0] g;
    logic [7:0] po, pe;
  } vec_t;

  vec_t tv[26];

  uio_port_arbiter #(.NUM_REQ(2), .TURN_CYC(1), .MAX_HOLD(4)) dut_a (
    .clock   (clock),
    .reset   (reset),
    .req     (a_req),
    .req_out (a_out),
    .req_oe  (a_oe),
    .grant   (a_grant),
    .rd_data (a_rd),
    .uio_in  (a_uin),
    .uio_out (a_uout),
    .uio_oe  (a_uoe)
  );

  uio_port_arbiter #(.NUM_REQ(2), .TURN_CYC(2), .MAX_HOLD(0)) dut_b (
    .clock   (clock),
    .reset   (reset),
    .req     (b_req),
    .req_out (b_out),
    .req_oe  (b_oe),
    .grant   (b_grant),
    .rd_data (b_rd),
    .uio_in  (b_uin),
    .uio_out (b_uout),
    .uio_oe  (b_uoe)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    checks++;
    if (!$onehot0(a_grant) || !$onehot0(b_grant)) begin
      errors++;
      $display("FAIL grant_onehot actual=%0h/%0h expected=onehot0", a_grant, b_grant);
    end
  end

  initial begin
    int held;
    reset = 1'b1;
    a_req = '0; a_out = '0; a_oe = '0; a_uin = '0;
    b_req = '0; b_out = '0; b_oe = '0; b_uin = '0;
    repeat (2) tick();
    chk("reset grant", {14'd0, a_grant}, 16'h0);
    chk("reset uio_out", {8'd0, a_uout}, 16'h0);
    chk("reset uio_oe", {8'd0, a_uoe}, 16'h0);
    chk("reset rd_data", {8'd0, a_rd}, 16'h0);
    chk("reset b grant", {14'd0, b_grant}, 16'h0);
    reset = 1'b0;

    //        req    o0     e0     o1     e1     grant  pad_out pad_oe
    tv[0]  = '{2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00};
    tv[1]  = '{2'b11, 8'hA5, 8'hFF, 8'h5A, 8'h0F, 2'b00, 8'h00, 8'h00};
    tv[2]  = '{2'b11, 8'hA5, 8'hFF, 8'h5A, 8'h0F, 2'b01, 8'h00, 8'h00};
    tv[3]  = '{2'b11, 8'hA5, 8'hFF, 8'h5A, 8'h0F, 2'b01, 8'hA5, 8'hFF};
    tv[4]  = '{2'b10, 8'hA5, 8'hFF, 8'h5A, 8'h0F, 2'b00, 8'h00, 8'h00};
    tv[5]  = '{2'b10, 8'hA5, 8'hFF, 8'h5A, 8'h0F, 2'b10, 8'h00, 8'h00};
    tv[6]  = '{2'b10, 8'hA5, 8'hFF, 8'h5A, 8'h0F, 2'b10, 8'h5A, 8'h0F};
    tv[7]  = '{2'b11, 8'h99, 8'h99, 8'hC3, 8'h33, 2'b10, 8'hC3, 8'h33};
    tv[8]  = '{2'b11, 8'h99, 8'h99, 8'h11, 8'h01, 2'b10, 8'h11, 8'h01};
    tv[9]  = '{2'b11, 8'h99, 8'h99, 8'h22, 8'h02, 2'b00, 8'h00, 8'h00};
    tv[10] = '{2'b11, 8'h12, 8'h34, 8'h22, 8'h02, 2'b01, 8'h00, 8'h00};
    tv[11] = '{2'b11, 8'hA5, 8'hFF, 8'h77, 8'h77, 2'b01, 8'hA5, 8'hFF};
    tv[12] = '{2'b11, 8'h01, 8'h80, 8'h77, 8'h77, 2'b01, 8'h01, 8'h80};
    tv[13] = '{2'b11, 8'hFE, 8'h7F, 8'h77, 8'h77, 2'b01, 8'hFE, 8'h7F};
    tv[14] = '{2'b11, 8'h44, 8'h44, 8'h77, 8'h77, 2'b00, 8'h00, 8'h00};
    tv[15] = '{2'b01, 8'h44, 8'h44, 8'h77, 8'h77, 2'b01, 8'h00, 8'h00};
    tv[16] = '{2'b01, 8'h3C, 8'hF0, 8'h77, 8'h77, 2'b01, 8'h3C, 8'hF0};
    tv[17] = '{2'b00, 8'h3C, 8'hF0, 8'h77, 8'h77, 2'b00, 8'h00, 8'h00};
    tv[18] = '{2'b01, 8'h3C, 8'hF0, 8'h77, 8'h77, 2'b00, 8'h00, 8'h00};
    tv[19] = '{2'b00, 8'h3C, 8'hF0, 8'h77, 8'h77, 2'b00, 8'h00, 8'h00};
    tv[20] = '{2'b00, 8'h3C, 8'hF0, 8'h77, 8'h77, 2'b00, 8'h00, 8'h00};
    tv[21] = '{2'b10, 8'h3C, 8'hF0, 8'h77, 8'h77, 2'b00, 8'h00, 8'h00};
    tv[22] = '{2'b10, 8'h3C, 8'hF0, 8'h77, 8'h77, 2'b10, 8'h00, 8'h00};
    tv[23] = '{2'b10, 8'h3C, 8'hF0, 8'h6B, 8'hB6, 2'b10, 8'h6B, 8'hB6};
    tv[24] = '{2'b00, 8'h3C, 8'hF0, 8'h6B, 8'hB6, 2'b00, 8'h00, 8'h00};
    tv[25] = '{2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00};

    for (int i = 0; i < 26; i++) begin
      logic [7:0] pad_in;
      pad_in = 8'(i * 29 + 7);
      a_req  = tv[i].req;
      a_out  = {tv[i].o1, tv[i].o0};
      a_oe   = {tv[i].e1, tv[i].e0};
      a_uin  = pad_in;
      tick();
      chk($sformatf("row%0d grant", i), {14'd0, a_grant}, {14'd0, tv[i].g});
      chk($sformatf("row%0d uio_out", i), {8'd0, a_uout}, {8'd0, tv[i].po});
      chk($sformatf("row%0d uio_oe", i), {8'd0, a_uoe}, {8'd0, tv[i].pe});
      chk($sformatf("row%0d rd_data", i), {8'd0, a_rd}, {8'd0, pad_in});
    end

    // Two-cycle turnaround, unlimited hold.
    b_out = {8'hEE, 8'hC0};
    b_oe  = {8'hEE, 8'h0C};
    b_req = 2'b01;
    tick(); chk("b turn1 grant", {14'd0, b_grant}, 16'h0);
    tick(); chk("b turn2 grant", {14'd0, b_grant}, 16'h0);
    tick(); chk("b first grant", {14'd0, b_grant}, 16'h1);
    chk("b first own pads", {8'd0, b_uoe}, 16'h0);
    tick(); chk("b pad out", {8'd0, b_uout}, 16'hC0);
    chk("b pad oe", {8'd0, b_uoe}, 16'h0C);
    b_req = 2'b11;
    held = 0;
    repeat (300) begin
      tick();
      if (b_grant == 2'b01) held++;
    end
    chk("b unlimited hold", 16'(held), 16'd300);
    b_req = 2'b10;
    tick(); chk("b release grant", {14'd0, b_grant}, 16'h0);
    chk("b release oe", {8'd0, b_uoe}, 16'h0);
    tick(); chk("b turn grant", {14'd0, b_grant}, 16'h0);
    tick(); chk("b next grant", {14'd0, b_grant}, 16'h2);
    tick(); chk("b next pad out", {8'd0, b_uout}, 16'hEE);
    b_req = 2'b00;
    tick();

    // Asynchronous reset while dut_a owns the pads.
    a_req = 2'b01;
    a_out = {8'h00, 8'hA5};
    a_oe  = {8'h00, 8'hFF};
    repeat (3) tick();
    chk("pre-reset grant", {14'd0, a_grant}, 16'h1);
    chk("pre-reset oe", {8'd0, a_uoe}, 16'hFF);
    #2 reset = 1'b1;
    #1;
    chk("async reset grant", {14'd0, a_grant}, 16'h0);
    chk("async reset oe", {8'd0, a_uoe}, 16'h0);
    chk("async reset out", {8'd0, a_uout}, 16'h0);
    tick();
    reset = 1'b0;
    a_req = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_port_arbiter.md
# uio_port_arbiter

Sequential arbiter sharing the 8 bidirectional `uio` pads between up to four internal requesters inside the Chisel top level. Grants the pads round-robin, inserts a configurable all-inputs turnaround window between owners so two drivers never overlap, bounds ownership with a hold limit, and drives registered, glitch-free `uio_out`/`uio_oe`. Sits between the requesting datapath units and the `uio_*` ports of the top wrapper.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4
- `TURN_CYC`, 1: turnaround cycles with `uio_oe`=0 before each grant, 1..7
- `MAX_HOLD`, 16: OWN cycles before forced release if another requester waits; 0 = unlimited; max 255

Ports:
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req` in NUM_REQ: request per requester, level, held until done
- `req_out` in 8*NUM_REQ: requester i pad data in bits [8i+7:8i]
- `req_oe` in 8*NUM_REQ: requester i pad enables, same slicing
- `grant` out NUM_REQ: one-hot or zero, registered
- `rd_data` out 8: `uio_in` registered once, broadcast to all
- `uio_in` in 8: pad input
- `uio_out` out 8: pad output, registered
- `uio_oe` out 8: pad enable, registered, 1 = drive

## Operation
- States: IDLE, TURN, OWN. Owner index and RR pointer (log2 NUM_REQ bits) registered.
- IDLE: if any `req` set → latch winner, load turn counter TURN_CYC-1, go TURN.
- TURN: `uio_oe`=0; counter decrements; at 0 → OWN, `grant[winner]`=1, hold counter cleared.
- OWN: each cycle registers `uio_out`<=slice(req_out,owner), `uio_oe`<=slice(req_oe,owner); hold counter increments, saturating at 255.
- OWN exit on `req[owner]`=0, or on hold count = MAX_HOLD-1 (MAX_HOLD≠0) with another `req` set (forced release). Exit → TURN with new winner if any other/remaining `req` set, else IDLE. Force-released owner with `req` still high stays pending.
- Winner: first set `req` at index ≥ pointer, wrapping modulo NUM_REQ. Pointer <= owner+1 mod NUM_REQ on each grant.
- Outside OWN: `uio_oe`=0, `uio_out`=0, `grant`=0.
- `rd_data` <= `uio_in` every cycle regardless of state.

## Timing
- Reset values: all outputs 0; state IDLE; pointer 0; counters 0. Reset mid-OWN drops `grant` and `uio_oe` asynchronously.
- `req` first seen high in IDLE at cycle t → TURN cycles t+1..t+TURN_CYC → `grant` high from t+TURN_CYC+1.
- Pad latency 1: pads at cycle k+1 reflect owner slices at cycle k when `grant` high at k; first OWN cycle pads still 0.
- Release: `req[owner]` low at cycle k → `grant` low at k+1, `uio_oe`=0 at k+1; next owner granted at k+1+TURN_CYC.
- Forced release at hold count MAX_HOLD-1 → OWN lasts exactly MAX_HOLD cycles.
- Simultaneous requests resolved solely by pointer; a requester dropping `req` during TURN before its grant: winner re-evaluated at TURN end; none set → IDLE.
- `grant` never high for two requesters; never high during TURN.

## Structure
- Package `uio_arb_pkg`: state enum (IDLE/TURN/OWN), MAX_REQ=4, width constants for turn and hold counters.
- Sub-module `rr_pick`: combinational round-robin picker (req vector, pointer → valid, index). Everything else in `uio_port_arbiter`.

## Test plan
- Reset → `grant`=0, `uio_oe`=0x00, `uio_out`=0x00; assert `reset` mid-OWN → all outputs 0 same cycle.
- NUM_REQ=2, TURN_CYC=1: req0 at t with req_out0=0xA5, req_oe0=0xFF → grant0 at t+2, `uio_out`=0xA5/`uio_oe`=0xFF at t+3.
- req0 and req1 asserted together from IDLE, pointer 0 → req0 granted first; req0 drops → one TURN cycle with `uio_oe`=0, then grant1.
- MAX_HOLD=4, req0 held high, req1 asserted → grant0 exactly 4 cycles, TURN, grant1; req1 drops → req0 regranted.
- MAX_HOLD=0 with req1 waiting → req0 holds 300 cycles with no forced release; hold counter saturates.
- `uio_in`=0x3C at cycle k → `rd_data`=0x3C at k+1 in every state.
